// File: rtl/matmul_control_path.sv
// rtl/matmul_control_path.sv - NxN matrix multiply sequencer: memory reads, accumulate, C writes
module matmul_control_path #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  en_ReadMat_A,
    output logic                  en_WriteMat_A,
    output logic [3:0]            rowAddr_A,
    output logic [3:0]            colAddr_A,
    output logic [DATA_WIDTH-1:0] writeData_A,
    input  logic [DATA_WIDTH-1:0] readData_A,
    output logic                  en_ReadMat_B,
    output logic                  en_WriteMat_B,
    output logic [3:0]            rowAddr_B,
    output logic [3:0]            colAddr_B,
    output logic [DATA_WIDTH-1:0] writeData_B,
    input  logic [DATA_WIDTH-1:0] readData_B,
    output logic                  en_Mux,
    output logic                  en_PPReg,
    output logic                  en_FDReg,
    output logic                  en_ReadMat_C,
    output logic                  en_WriteMat_C,
    output logic [3:0]            rowAddr_C,
    output logic [3:0]            colAddr_C,
    output logic [DATA_WIDTH-1:0] writeData_C,
    input  logic [DATA_WIDTH-1:0] readData_C
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_ACC, S_FD, S_WRITE, S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(N - 1);

    state_t                state_q, state_d;
    logic [3:0]            i_q, j_q, k_q, i_d, j_d, k_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, fd_q, prod;
    logic [3:0]            row_a_q, col_a_q, row_b_q, col_b_q, row_c_q, col_c_q;
    logic                  unused_read_c;

    assign unused_read_c = ^readData_C;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE:  state_d = S_READ;
            S_READ:  state_d = S_ACC;
            S_ACC: begin
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = S_FD;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = S_READ;
                end
            end
            S_FD:    state_d = S_WRITE;
            S_WRITE: begin
                if (j_q == LAST && i_q == LAST) begin
                    state_d = S_DONE;
                end else if (j_q == LAST) begin
                    j_d     = '0;
                    i_d     = i_q + 4'd1;
                    state_d = S_READ;
                end else begin
                    j_d     = j_q + 4'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    always_comb begin
        en_ReadMat_A  = (state_q == S_READ);
        en_ReadMat_B  = (state_q == S_READ);
        en_PPReg      = (state_q == S_ACC);
        en_Mux        = (state_q == S_ACC) && (k_q != 4'd0);
        en_FDReg      = (state_q == S_FD);
        en_WriteMat_C = (state_q == S_WRITE);
    end

    // Mirror of the datapath: products and sums wrap at DATA_WIDTH.
    assign prod  = readData_A * readData_B;
    assign acc_d = (en_Mux ? acc_q : '0) + prod;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            fd_q    <= '0;
            row_a_q <= '0;
            col_a_q <= '0;
            row_b_q <= '0;
            col_b_q <= '0;
            row_c_q <= '0;
            col_c_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            if (state_q == S_ACC) acc_q <= acc_d;
            if (state_q == S_FD)  fd_q  <= acc_q;
            // Addresses are loaded on entry so they are valid during the strobe cycle.
            if (state_d == S_READ) begin
                row_a_q <= i_d;
                col_a_q <= k_d;
                row_b_q <= k_d;
                col_b_q <= j_d;
            end
            if (state_d == S_WRITE) begin
                row_c_q <= i_q;
                col_c_q <= j_q;
            end
        end
    end

    assign rowAddr_A     = row_a_q;
    assign colAddr_A     = col_a_q;
    assign rowAddr_B     = row_b_q;
    assign colAddr_B     = col_b_q;
    assign rowAddr_C     = row_c_q;
    assign colAddr_C     = col_c_q;
    assign writeData_C   = fd_q;
    assign en_WriteMat_A = 1'b0;
    assign en_WriteMat_B = 1'b0;
    assign en_ReadMat_C  = 1'b0;
    assign writeData_A   = '0;
    assign writeData_B   = '0;

endmodule

// File: tb/tb_matmul_control_path.sv
// tb/tb_matmul_control_path.sv - scoreboard bench for matmul_control_path
module tb_matmul_control_path;

    localparam int DW = 8;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          en_ReadMat_A, en_WriteMat_A, en_ReadMat_B, en_WriteMat_B;
    logic          en_Mux, en_PPReg, en_FDReg, en_ReadMat_C, en_WriteMat_C;
    logic [3:0]    rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C;
    logic [DW-1:0] writeData_A, writeData_B, writeData_C;
    logic [DW-1:0] readData_A = '0, readData_B = '0, readData_C = '0;

    logic [DW-1:0] mem_a [16][16];
    logic [DW-1:0] mem_b [16][16];
    logic [DW-1:0] mem_c [16][16];
    logic [DW-1:0] exp_c [N][N];

    typedef struct {
        logic [3:0]    r;
        logic [3:0]    c;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_control_path #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .en_ReadMat_A(en_ReadMat_A), .en_WriteMat_A(en_WriteMat_A),
        .rowAddr_A(rowAddr_A), .colAddr_A(colAddr_A),
        .writeData_A(writeData_A), .readData_A(readData_A),
        .en_ReadMat_B(en_ReadMat_B), .en_WriteMat_B(en_WriteMat_B),
        .rowAddr_B(rowAddr_B), .colAddr_B(colAddr_B),
        .writeData_B(writeData_B), .readData_B(readData_B),
        .en_Mux(en_Mux), .en_PPReg(en_PPReg), .en_FDReg(en_FDReg),
        .en_ReadMat_C(en_ReadMat_C), .en_WriteMat_C(en_WriteMat_C),
        .rowAddr_C(rowAddr_C), .colAddr_C(colAddr_C),
        .writeData_C(writeData_C), .readData_C(readData_C)
    );

    always @(posedge clk) begin
        if (en_ReadMat_A)  readData_A <= mem_a[rowAddr_A][colAddr_A];
        if (en_ReadMat_B)  readData_B <= mem_b[rowAddr_B][colAddr_B];
        if (en_WriteMat_C) mem_c[rowAddr_C][colAddr_C] <= writeData_C;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_strobes(input int c);
        int p;
        if (c < 2 || c > 161) return 5'b00000;
        p = (c - 2) % 10;
        if (p < 8) return (p % 2 == 0) ? 5'b11000 : 5'b00100;
        if (p == 8) return 5'b00010;
        return 5'b00001;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {26'd0, en_ReadMat_A, en_ReadMat_B, en_PPReg, en_FDReg, en_WriteMat_C, en_Mux,
                rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C, writeData_C};
    endfunction

    task automatic load_mats(input int mode);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mem_a[r][c] = '0;
                mem_b[r][c] = '0;
                mem_c[r][c] = 8'hEE;
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0: begin mem_a[r][c] = (r == c) ? 8'd1 : 8'd0; mem_b[r][c] = 8'(4 * r + c); end
                    1: begin mem_a[r][c] = 8'h02; mem_b[r][c] = 8'h02; end
                    2: begin mem_a[r][c] = 8'h10; mem_b[r][c] = 8'h10; end
                    default: begin mem_a[r][c] = 8'($urandom); mem_b[r][c] = 8'($urandom); end
                endcase
    endtask

    task automatic build_expected();
        logic [DW-1:0] s;
        exp_t e;
        sb.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + mem_a[i][k] * mem_b[k][j];
                exp_c[i][j] = s;
                e.r = 4'(i); e.c = 4'(j); e.d = s; e.cyc = 11 + 10 * (N * i + j);
                sb.push_back(e);
            end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk); #1 reset_n = 1'b0;
    endtask

    task automatic sample(input int c);
        int p, e;
        logic [3:0] ii, jj, kk;
        exp_t x;
        check("strobes", {en_ReadMat_A, en_ReadMat_B, en_PPReg, en_FDReg, en_WriteMat_C}, exp_strobes(c));
        check("tied_zero", {en_WriteMat_A, en_WriteMat_B, en_ReadMat_C, writeData_A, writeData_B}, 64'd0);
        if (c >= 2 && c <= 161) begin
            p  = (c - 2) % 10;
            e  = (c - 2) / 10;
            ii = 4'(e / N);
            jj = 4'(e % N);
            kk = 4'(p / 2);
            if (p < 8 && p % 2 == 0)
                check("rd_addr", {rowAddr_A, colAddr_A, rowAddr_B, colAddr_B}, {ii, kk, kk, jj});
            if (p < 8 && p % 2 == 1)
                check("en_mux", en_Mux, kk != 4'd0);
        end
        if (en_WriteMat_C) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                x = sb.pop_front();
                check("wr_addr", {rowAddr_C, colAddr_C}, {x.r, x.c});
                check("wr_data", writeData_C, x.d);
                check("wr_cycle", c, x.cyc);
            end
        end
    endtask

    task automatic run_seq(input int reset_at);
        build_expected();
        apply_reset();
        for (int c = 1; c <= 175; c++) begin
            if (reset_at != 0 && c == reset_at) begin
                @(posedge clk); #2 reset_n = 1'b1;
                #1 check("async_reset_outputs", all_outputs(), 64'd0);
                return;
            end
            @(negedge clk);
            sample(c);
        end
        check("sb_empty", sb.size(), 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check("c_mem", mem_c[i][j], exp_c[i][j]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        load_mats(0); run_seq(0);
        load_mats(1); run_seq(0);
        load_mats(2); run_seq(0);
        load_mats(3); run_seq(35);
        run_seq(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
